// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer owning the PC, with an IF/ID output slot, redirect/flush and terminal halt
module fetch_controller #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic        Halt,
    input  logic        OutReady,
    output logic        OutValid,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4,
    output logic        Halted,
    output logic [31:0] FetchCount
);
    typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic [31:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4       = pc_q + 32'd4;
    assign target         = {RedirectTarget[31:2], 2'b00};
    assign ImemAddress    = pc_q;
    assign OutValid       = valid_q;
    assign OutInstruction = instr_q;
    assign OutPC          = out_pc_q;
    assign OutPCPlus4     = out_pc4_q;
    assign Halted         = halted_q;
    assign FetchCount     = count_q;

    // Next state: halt beats redirect, redirect beats capture, capture beats stall
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        out_pc_d  = out_pc_q;
        out_pc4_d = out_pc4_q;
        count_d   = count_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        case (state_q)
            BOOT: begin
                if (Halt) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else begin
                    state_d = FETCH;
                    if (Redirect) pc_d = target;
                end
            end
            FETCH: begin
                if (Halt) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    if (OutReady) valid_d = 1'b0;
                end else if (Redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end else if (!valid_q || OutReady) begin
                    instr_d   = ImemInstruction;
                    out_pc_d  = pc_q;
                    out_pc4_d = pc_plus4;
                    valid_d   = 1'b1;
                    pc_d      = pc_plus4;
                    count_d   = count_q + 32'd1;
                end
            end
            default: begin
                if (OutReady) valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= BOOT;
            pc_q      <= PC_RESET;
            instr_q   <= 32'd0;
            out_pc_q  <= 32'd0;
            out_pc4_q <= 32'd0;
            count_q   <= 32'd0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            out_pc_q  <= out_pc_d;
            out_pc4_q <= out_pc4_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: scoreboard bench with a behavioural fetch model, directed plan cases and random traffic
module tb_fetch_controller;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] ImemAddress, ImemInstruction;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'd0;
    logic        Halt = 1'b0;
    logic        OutReady = 1'b0;
    logic        OutValid, Halted;
    logic [31:0] OutInstruction, OutPC, OutPCPlus4, FetchCount;

    logic [31:0] w_addr, w_imem, w_instr, w_pc, w_pc4, w_count;
    logic        w_valid, w_halted;

    logic [31:0] mem [128];

    assign ImemInstruction = mem[ImemAddress[8:2]];
    assign w_imem          = mem[w_addr[8:2]];

    always #5 Clk = ~Clk;

    fetch_controller #(.PC_RESET(32'h0000_0000)) dut (
        .Clk(Clk), .Reset(Reset), .ImemAddress(ImemAddress), .ImemInstruction(ImemInstruction),
        .Redirect(Redirect), .RedirectTarget(RedirectTarget), .Halt(Halt), .OutReady(OutReady),
        .OutValid(OutValid), .OutInstruction(OutInstruction), .OutPC(OutPC),
        .OutPCPlus4(OutPCPlus4), .Halted(Halted), .FetchCount(FetchCount)
    );

    fetch_controller #(.PC_RESET(32'h0000_01FC)) dut_w (
        .Clk(Clk), .Reset(Reset), .ImemAddress(w_addr), .ImemInstruction(w_imem),
        .Redirect(Redirect), .RedirectTarget(RedirectTarget), .Halt(Halt), .OutReady(OutReady),
        .OutValid(w_valid), .OutInstruction(w_instr), .OutPC(w_pc),
        .OutPCPlus4(w_pc4), .Halted(w_halted), .FetchCount(w_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] count;
    } cap_t;

    localparam int M_BOOT = 0, M_FETCH = 1, M_HALT = 2;

    cap_t        exp_q [$];
    int          vectors = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    int          m_state;
    logic [31:0] m_pc, m_count, last_fc;
    bit          m_valid, m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one clock edge of the fetch rules, recording every capture it predicts
    task automatic model_edge(input bit rd, input logic [31:0] tg, input bit hl, input bit rdy);
        if (m_state == M_BOOT) begin
            if (hl) begin
                m_state = M_HALT;
                m_halt  = 1'b1;
            end else begin
                m_state = M_FETCH;
                if (rd) m_pc = tg & ~32'd3;
            end
        end else if (m_state == M_FETCH) begin
            if (hl) begin
                m_state = M_HALT;
                m_halt  = 1'b1;
                if (rdy) m_valid = 1'b0;
            end else if (rd) begin
                m_pc    = tg & ~32'd3;
                m_valid = 1'b0;
            end else if (!m_valid || rdy) begin
                m_count = m_count + 1;
                exp_q.push_back('{mem[m_pc[8:2]], m_pc, m_pc + 4, m_count});
                m_pc    = m_pc + 4;
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit rd, input logic [31:0] tg, input bit hl, input bit rdy);
        Redirect       = rd;
        RedirectTarget = tg;
        Halt           = hl;
        OutReady       = rdy;
        @(posedge Clk);
        model_edge(rd, tg, hl, rdy);
        @(negedge Clk);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear without an edge
    task automatic do_reset();
        #2 Reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, OutValid}, 32'd0);
        check("rst_instr", OutInstruction, 32'd0);
        check("rst_pc", OutPC, 32'd0);
        check("rst_pc4", OutPCPlus4, 32'd0);
        check("rst_halted", {31'd0, Halted}, 32'd0);
        check("rst_count", FetchCount, 32'd0);
        check("rst_addr", ImemAddress, 32'd0);
        check("rst_w_addr", w_addr, 32'h0000_01FC);
        m_state = M_BOOT;
        m_pc    = 32'd0;
        m_count = 32'd0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        last_fc = 32'd0;
        exp_q.delete();
        #1 Reset = 1'b1;
    endtask

    // Monitor: cycle-level status against the model, and pops a predicted capture whenever a new one shows up
    always @(negedge Clk) begin
        if (mon_en) begin
            check("valid", {31'd0, OutValid}, {31'd0, m_valid});
            check("halted", {31'd0, Halted}, {31'd0, m_halt});
            check("imem_addr", ImemAddress, m_pc);
            check("fetch_count", FetchCount, m_count);
            if (OutValid && FetchCount != last_fc) begin
                last_fc = FetchCount;
                if (exp_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL capture: unexpected capture pc %h, none predicted", OutPC);
                end else begin
                    cap_t e;
                    e = exp_q.pop_front();
                    check("cap_instr", OutInstruction, e.instr);
                    check("cap_pc", OutPC, e.pc);
                    check("cap_pc4", OutPCPlus4, e.pc4);
                    check("cap_count", FetchCount, e.count);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
        repeat (2) @(negedge Clk);
        do_reset();
        mon_en = 1'b1;

        // Straight-line fetch from reset
        step(0, 0, 0, 1);
        check("boot_no_valid", {31'd0, OutValid}, 32'd0);
        step(0, 0, 0, 1);
        check("first_valid", {31'd0, OutValid}, 32'd1);
        check("first_pc", OutPC, 32'd0);
        check("w_first_instr", w_instr, 32'h0000_01FC);
        check("w_first_pc4", w_pc4, 32'h0000_0200);
        step(0, 0, 0, 1);
        check("second_pc4", OutPCPlus4, 32'd8);
        check("w_second_pc", w_pc, 32'h0000_0200);
        check("w_second_instr", w_instr, 32'd0);
        step(0, 0, 0, 1);
        check("third_pc", OutPC, 32'd8);

        // Backpressure holds slot, PC and count
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("stall_pc", OutPC, 32'd8);
            check("stall_addr", ImemAddress, 32'd12);
            check("stall_count", FetchCount, 32'd3);
        end
        step(0, 0, 0, 1);
        check("release_pc", OutPC, 32'd12);
        check("release_instr", OutInstruction, 32'd12);
        check("release_count", FetchCount, 32'd4);

        // Redirect over a pending slot
        do_reset();
        repeat (4) step(0, 0, 0, 1);
        check("pre_redirect_pc", OutPC, 32'd8);
        step(1, 32'h0000_0043, 0, 0);
        check("redirect_bubble", {31'd0, OutValid}, 32'd0);
        check("redirect_addr", ImemAddress, 32'h0000_0040);
        step(0, 0, 0, 0);
        check("target_instr", OutInstruction, 32'h0000_0040);
        check("target_pc", OutPC, 32'h0000_0040);

        // Halt together with redirect while the slot is pending
        step(1, 32'h0000_0100, 1, 0);
        check("halt_flag", {31'd0, Halted}, 32'd1);
        check("halt_addr", ImemAddress, 32'h0000_0044);
        check("halt_slot_kept", {31'd0, OutValid}, 32'd1);
        repeat (2) step(0, 0, 0, 0);
        check("halt_slot_still", {31'd0, OutValid}, 32'd1);
        step(0, 0, 0, 1);
        check("halt_slot_drained", {31'd0, OutValid}, 32'd0);
        for (int i = 0; i < 10; i++) step(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
        check("halt_no_capture", FetchCount, 32'd4);
        check("halt_frozen_addr", ImemAddress, 32'h0000_0044);
        check("halt_valid_off", {31'd0, OutValid}, 32'd0);

        // Reset pulse mid-stream restarts with a BOOT cycle
        repeat (3) step(0, 0, 0, 1);
        do_reset();
        step(0, 0, 0, 1);
        check("reboot_no_valid", {31'd0, OutValid}, 32'd0);
        step(0, 0, 0, 1);
        check("reboot_pc", OutPC, 32'd0);

        // Random traffic against the model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 128; i++) mem[i] = $urandom;
            do_reset();
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 149) == 0) do_reset();
                step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 99) == 0,
                     $urandom_range(0, 9) < 7);
            end
        end

        step(0, 0, 0, 0);
        #1;
        check("leftover_captures", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
